// File: rtl/lm_sm_sequencer.sv
// LM/SM micro-op sequencer: cracks a register bitmap into per-register uops.
// Optional LMSM_PERF_EN adds the perf_uops accepted-uop counter port.
module lm_sm_sequencer #(
  parameter int         ADDR_W    = 16,
  parameter int         ADDR_STEP = 1,
  parameter logic [3:0] OP_LM     = 4'b0110,
  parameter logic [3:0] OP_SM     = 4'b0111
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [7:0]        imm,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              flush,
  input  logic              uop_ready,
  output logic              stall_fetch,
  output logic              busy,
  output logic              uop_valid,
  output logic              uop_is_load,
  output logic [2:0]        uop_reg,
  output logic [ADDR_W-1:0] uop_addr,
  output logic              done
`ifdef LMSM_PERF_EN
  ,
  output logic [15:0]       perf_uops
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    FINISH
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [7:0]        mask;
  logic [7:0]        mask_nx;
  logic [ADDR_W-1:0] addr;
  logic              is_load;
  logic              is_lmsm;
  logic              accept;
  logic              fire;
  logic              last;

  assign is_lmsm = (op == OP_LM) | (op == OP_SM);
  assign accept  = start & is_lmsm & (state == IDLE) & ~flush;
  assign fire    = uop_valid & uop_ready;
  // clear lowest set bit
  assign mask_nx = mask & (mask - 8'd1);
  assign last    = (mask_nx == 8'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept)
          state_nx = (imm != 8'd0) ? ISSUE : FINISH;
      end
      ISSUE: begin
        if (fire && last) state_nx = IDLE;
      end
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask    <= 8'd0;
      addr    <= '0;
      is_load <= 1'b0;
    end else if (flush) begin
      mask <= 8'd0;
    end else if (accept) begin
      mask    <= imm;
      addr    <= base_addr;
      is_load <= (op == OP_LM);
    end else if (fire) begin
      mask <= mask_nx;
      addr <= addr + ADDR_W'(ADDR_STEP);
    end
  end

  always_comb begin
    busy        = (state != IDLE);
    uop_valid   = (state == ISSUE);
    stall_fetch = accept | busy;
    uop_is_load = uop_valid & is_load;
    uop_addr    = uop_valid ? addr : '0;
    done        = ~flush & (((state == ISSUE) & uop_ready & last) |
                            (state == FINISH));
    uop_reg     = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (mask[i]) uop_reg = 3'(i);
  end

`ifdef LMSM_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      perf_uops <= 16'd0;
    else if (fire && perf_uops != 16'hFFFF)
      perf_uops <= perf_uops + 16'd1;
  end
`endif

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Directed self-checking bench for lm_sm_sequencer.
// Build with LMSM_PERF_EN defined to also check perf_uops.
module tb_lm_sm_sequencer;

  localparam logic [3:0] LM = 4'b0110;
  localparam logic [3:0] SM = 4'b0111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  op;
  logic [7:0]  imm;
  logic [15:0] base_addr;
  logic        flush;
  logic        uop_ready;
  logic        stall_fetch;
  logic        busy;
  logic        uop_valid;
  logic        uop_is_load;
  logic [2:0]  uop_reg;
  logic [15:0] uop_addr;
  logic        done;
`ifdef LMSM_PERF_EN
  logic [15:0] perf_uops;
`endif

  int tests = 0;
  int fails = 0;

  lm_sm_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .imm         (imm),
    .base_addr   (base_addr),
    .flush       (flush),
    .uop_ready   (uop_ready),
    .stall_fetch (stall_fetch),
    .busy        (busy),
    .uop_valid   (uop_valid),
    .uop_is_load (uop_is_load),
    .uop_reg     (uop_reg),
    .uop_addr    (uop_addr),
    .done        (done)
`ifdef LMSM_PERF_EN
    ,
    .perf_uops   (perf_uops)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    tests++;
    if ({stall_fetch, busy, uop_valid, uop_is_load, done} !== 5'b0 ||
        uop_reg !== 3'd0 || uop_addr !== 16'd0) begin
      fails++;
      $display("FAIL %s idle: stall=%b busy=%b v=%b ld=%b d=%b r=%0d a=%h expected all 0",
               tag, stall_fetch, busy, uop_valid, uop_is_load, done,
               uop_reg, uop_addr);
    end
  endtask

  task automatic chk_uop(input string tag, input logic [2:0] r,
                         input logic [15:0] a, input logic ld,
                         input logic d);
    tests++;
    if (uop_valid !== 1'b1 || uop_reg !== r || uop_addr !== a ||
        uop_is_load !== ld || done !== d || stall_fetch !== 1'b1 ||
        busy !== 1'b1) begin
      fails++;
      $display("FAIL %s uop: v=%b r=%0d a=%h ld=%b d=%b st=%b b=%b expected v=1 r=%0d a=%h ld=%b d=%b st=1 b=1",
               tag, uop_valid, uop_reg, uop_addr, uop_is_load, done,
               stall_fetch, busy, r, a, ld, d);
    end
  endtask

  task automatic issue(input logic [3:0] o, input logic [7:0] m,
                       input logic [15:0] b);
    start = 1'b1; op = o; imm = m; base_addr = b;
    #1;
    chk("accept_stall", {15'd0, stall_fetch}, 16'd1);
    chk("accept_busy", {15'd0, busy}, 16'd0);
    tick();
    start = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 4'd0; imm = 8'd0;
    base_addr = 16'd0; flush = 1'b0; uop_ready = 1'b1;
    #2;
    chk_idle("reset");
`ifdef LMSM_PERF_EN
    chk("perf_reset", perf_uops, 16'd0);
`endif
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk_idle("post_reset");
  endtask

  task automatic test_lm_basic();
    logic [2:0] er [4];
    int stalls;
    er[0] = 3'd0; er[1] = 3'd2; er[2] = 3'd5; er[3] = 3'd7;
    stalls = 1;
    issue(LM, 8'b1010_0101, 16'h0040);
    for (int i = 0; i < 4; i++) begin
      chk_uop("lm_basic", er[i], 16'h0040 + 16'(i), 1'b1, i == 3);
      if (stall_fetch) stalls++;
      tick();
    end
    chk_idle("lm_basic_end");
    chk("lm_stall_cycles", 16'(stalls), 16'd5);
`ifdef LMSM_PERF_EN
    chk("perf_after_lm", perf_uops, 16'd4);
`endif
  endtask

  task automatic test_sm_wrap();
    issue(SM, 8'h80, 16'hFFFF);
    chk_uop("sm_single", 3'd7, 16'hFFFF, 1'b0, 1'b1);
    tick();
    chk_idle("sm_single_end");
    issue(LM, 8'h01, 16'h0005);
    chk_uop("follow_op", 3'd0, 16'h0005, 1'b1, 1'b1);
    tick();
    chk_idle("follow_end");
  endtask

  task automatic test_empty_mask();
    issue(LM, 8'h00, 16'h1234);
    chk("empty_valid", {15'd0, uop_valid}, 16'd0);
    chk("empty_done", {15'd0, done}, 16'd1);
    chk("empty_stall", {15'd0, stall_fetch}, 16'd1);
    chk("empty_busy", {15'd0, busy}, 16'd1);
    tick();
    chk_idle("empty_end");
  endtask

  task automatic test_backpressure();
    uop_ready = 1'b0;
    issue(SM, 8'h03, 16'h0010);
    for (int i = 0; i < 3; i++) begin
      chk_uop("hold", 3'd0, 16'h0010, 1'b0, 1'b0);
      tick();
    end
    uop_ready = 1'b1;
    #1;
    chk_uop("release", 3'd0, 16'h0010, 1'b0, 1'b0);
    tick();
    chk_uop("second", 3'd1, 16'h0011, 1'b0, 1'b1);
    tick();
    chk_idle("bp_end");
  endtask

  task automatic test_flush();
    issue(LM, 8'hFF, 16'h0100);
    chk_uop("fl_r0", 3'd0, 16'h0100, 1'b1, 1'b0);
    tick();
    chk_uop("fl_r1", 3'd1, 16'h0101, 1'b1, 1'b0);
    tick();
    flush = 1'b1;
    #1;
    chk_uop("fl_r2", 3'd2, 16'h0102, 1'b1, 1'b0);
    tick();
    flush = 1'b0;
    #1;
    chk_idle("flush_end");
    tick();
    chk_idle("flush_stays");
    start = 1'b1; op = SM; imm = 8'h0F; flush = 1'b1;
    #1;
    chk("flush_beats_start", {15'd0, stall_fetch}, 16'd0);
    tick();
    start = 1'b0; flush = 1'b0;
    #1;
    chk_idle("flush_start_end");
  endtask

  task automatic test_non_lmsm();
    start = 1'b1; op = 4'b0001; imm = 8'hFF; base_addr = 16'h00AA;
    #1;
    chk_idle("nonop_cycle");
    tick();
    chk_idle("nonop_next");
    start = 1'b0;
  endtask

  task automatic test_reset_mid();
    issue(LM, 8'hF0, 16'h0200);
    chk_uop("rm_r4", 3'd4, 16'h0200, 1'b1, 1'b0);
    tick();
    chk_uop("rm_r5", 3'd5, 16'h0201, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("reset_mid");
`ifdef LMSM_PERF_EN
    chk("perf_reset_mid", perf_uops, 16'd0);
`endif
    tick();
    rst_n = 1'b1;
    tick();
    chk_idle("reset_mid_after");
  endtask

  initial begin
    test_reset();
    test_lm_basic();
    test_sm_wrap();
    test_empty_mask();
    test_backpressure();
    test_flush();
    test_non_lmsm();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
